// File: rtl/pimc_irq_rx.sv
// PIMC interrupt message receiver: captures messages for this CPU into a
// small vector FIFO, acks the controller and offers vectors to the core.
module pimc_irq_rx #(
    parameter int unsigned CPU_ID     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          notify,
    input  logic [7:0]                    lineno,
    input  logic [7:0]                    processor_id,
    output logic                          irqack,
    input  logic                          irq_en,
    output logic                          irq_pending,
    output logic [7:0]                    irq_vector,
    input  logic                          irq_take,
    output logic                          rx_stall,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic match_c;
    logic full_c;
    logic pop_c;
    logic push_c;
    logic stall_c;

    assign match_c     = !notify && (processor_id == 8'(CPU_ID));
    assign full_c      = (count == CNT_W'(FIFO_DEPTH));
    assign irq_pending = (count != '0) && irq_en;
    assign pop_c       = irq_take && irq_pending;
    assign irq_vector  = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign fifo_count  = count;

    // Next-state: capture once per message, hold off while full, wait for release
    always_comb begin
        next_state = state;
        push_c     = 1'b0;
        stall_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (match_c) begin
                    if (!full_c || pop_c) begin
                        push_c     = 1'b1;
                        next_state = ACK;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end
            ACK: begin
                next_state = RELEASE;
            end
            RELEASE: begin
                if (notify) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            irqack   <= 1'b0;
            rx_stall <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= next_state;
            irqack   <= (next_state == ACK);
            rx_stall <= stall_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Vector storage needs no reset; reads are gated by count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= lineno;
        end
    end

endmodule

// File: tb/tb_pimc_irq_rx.sv
// Testbench for pimc_irq_rx: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pimc_irq_rx;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  MY_ID = 8'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       notify = 1'b1;
    logic [7:0] lineno = 8'h00;
    logic [7:0] processor_id = 8'h00;
    logic       irqack;
    logic       irq_en = 1'b1;
    logic       irq_pending;
    logic [7:0] irq_vector;
    logic       irq_take = 1'b0;
    logic       rx_stall;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;

    // Reference model: queued vectors, receiver phase (0 idle, 1 acking, 2 awaiting release)
    logic [7:0] m_q[$];
    int         m_phase = 0;
    logic       m_ack = 1'b0;
    logic       m_stall = 1'b0;

    pimc_irq_rx #(.CPU_ID(3), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .notify(notify), .lineno(lineno),
        .processor_id(processor_id), .irqack(irqack), .irq_en(irq_en),
        .irq_pending(irq_pending), .irq_vector(irq_vector), .irq_take(irq_take),
        .rx_stall(rx_stall), .fifo_count(fifo_count)
    );

    always #10 clk = ~clk;

    function automatic void model_reset();
        m_q.delete();
        m_phase = 0;
        m_ack = 1'b0;
        m_stall = 1'b0;
    endfunction

    function automatic void model_edge();
        logic pend, pop, match;
        pend = (m_q.size() != 0) && irq_en;
        pop = irq_take && pend;
        match = !notify && (processor_id == MY_ID);
        m_ack = 1'b0;
        m_stall = 1'b0;
        if (pop) void'(m_q.pop_front());
        case (m_phase)
            0: if (match) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(lineno);
                    m_ack = 1'b1;
                    m_phase = 1;
                end else begin
                    m_stall = 1'b1;
                end
            end
            1: m_phase = 2;
            default: if (notify) m_phase = 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    // Deliver one message and wait (bounded) for its ack, then release the bus
    task automatic send_msg(input logic [7:0] line);
        bit seen = 0;
        notify = 1'b0; processor_id = MY_ID; lineno = line;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (irqack) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL send_ack: line %0d got no irqack, want ack within 8 cycles", line);
        end
        notify = 1'b1;
        step();
        step();
    endtask

    task automatic drain();
        irq_take = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) step();
        irq_take = 1'b0;
        total++;
        if (fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL drain_count: got %0d want 0", fifo_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        total += 5;
        if (irqack !== 1'b0)      begin bad++; $display("FAIL reset_irqack: got %b want 0", irqack); end
        if (irq_pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", irq_pending); end
        if (irq_vector !== 8'h00) begin bad++; $display("FAIL reset_vector: got %h want 00", irq_vector); end
        if (rx_stall !== 1'b0)    begin bad++; $display("FAIL reset_stall: got %b want 0", rx_stall); end
        if (fifo_count !== 3'd0)  begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        notify = 1'b0; processor_id = MY_ID; lineno = 8'd5;
        step();
        total += 4;
        if (irqack !== 1'b1)      begin bad++; $display("FAIL single_ack: got %b want 1", irqack); end
        if (irq_vector !== 8'd5)  begin bad++; $display("FAIL single_vector: got %0d want 5", irq_vector); end
        if (irq_pending !== 1'b1) begin bad++; $display("FAIL single_pending: got %b want 1", irq_pending); end
        if (fifo_count !== 3'd1)  begin bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        for (int i = 0; i < 3; i++) begin
            step();
            total += 2;
            if (irqack !== 1'b0)     begin bad++; $display("FAIL single_hold_ack: cycle %0d got %b want 0", i, irqack); end
            if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_hold_count: cycle %0d got %0d want 1", i, fifo_count); end
        end
        notify = 1'b1;
        step();
        drain();
    endtask

    task automatic test_other_cpu();
        notify = 1'b0; processor_id = MY_ID + 8'd1; lineno = 8'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            total += 2;
            if (irqack !== 1'b0)     begin bad++; $display("FAIL other_ack: cycle %0d got %b want 0", i, irqack); end
            if (fifo_count !== 3'd0) begin bad++; $display("FAIL other_count: cycle %0d got %0d want 0", i, fifo_count); end
        end
        notify = 1'b1;
        step();
    endtask

    task automatic test_full_stall();
        logic [7:0] exp_order[4];
        exp_order = '{8'd2, 8'd3, 8'd4, 8'd9};
        for (int i = 1; i <= 4; i++) send_msg(8'(i));
        notify = 1'b0; processor_id = MY_ID; lineno = 8'd9;
        step();
        step();
        total += 3;
        if (rx_stall !== 1'b1)   begin bad++; $display("FAIL full_stall: got %b want 1", rx_stall); end
        if (irqack !== 1'b0)     begin bad++; $display("FAIL full_noack: got %b want 0", irqack); end
        if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        irq_take = 1'b1;
        step();
        irq_take = 1'b0;
        total += 3;
        if (irqack !== 1'b1)     begin bad++; $display("FAIL full_take_ack: got %b want 1", irqack); end
        if (rx_stall !== 1'b0)   begin bad++; $display("FAIL full_take_stall: got %b want 0", rx_stall); end
        if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_take_count: got %0d want 4", fifo_count); end
        notify = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (irq_vector !== exp_order[i]) begin
                bad++; $display("FAIL full_order: pop %0d got %0d want %0d", i, irq_vector, exp_order[i]);
            end
            irq_take = 1'b1;
            step();
            irq_take = 1'b0;
        end
        total++;
        if (fifo_count !== 3'd0) begin bad++; $display("FAIL full_empty: got %0d want 0", fifo_count); end
    endtask

    task automatic test_mask();
        send_msg(8'd7);
        send_msg(8'd8);
        irq_en = 1'b0;
        #1;
        total++;
        if (irq_pending !== 1'b0) begin bad++; $display("FAIL mask_pending: got %b want 0", irq_pending); end
        irq_take = 1'b1;
        step();
        step();
        irq_take = 1'b0;
        total++;
        if (fifo_count !== 3'd2) begin bad++; $display("FAIL mask_count: got %0d want 2", fifo_count); end
        irq_en = 1'b1;
        #1;
        total += 2;
        if (irq_pending !== 1'b1) begin bad++; $display("FAIL unmask_pending: got %b want 1", irq_pending); end
        if (irq_vector !== 8'd7)  begin bad++; $display("FAIL unmask_vector: got %0d want 7", irq_vector); end
        drain();
    endtask

    task automatic test_reset_mid_ack();
        int acks = 0;
        send_msg(8'h11);
        notify = 1'b0; processor_id = MY_ID; lineno = 8'h33;
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        total += 2;
        if (irqack !== 1'b0)     begin bad++; $display("FAIL rst_ack: got %b want 0", irqack); end
        if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (irqack) acks++;
        end
        total += 3;
        if (acks != 1)            begin bad++; $display("FAIL rst_recapture_acks: got %0d want 1", acks); end
        if (fifo_count !== 3'd1)  begin bad++; $display("FAIL rst_recapture_count: got %0d want 1", fifo_count); end
        if (irq_vector !== 8'h33) begin bad++; $display("FAIL rst_recapture_vector: got %h want 33", irq_vector); end
        notify = 1'b1;
        step();
        drain();
    endtask

    task automatic test_back_to_back();
        send_msg(8'd21);
        send_msg(8'd22);
        notify = 1'b0; processor_id = MY_ID; lineno = 8'd23;
        irq_take = 1'b1;
        step();
        irq_take = 1'b0;
        notify = 1'b1;
        total += 3;
        if (irqack !== 1'b1)      begin bad++; $display("FAIL b2b_ack: got %b want 1", irqack); end
        if (fifo_count !== 3'd2)  begin bad++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
        if (irq_vector !== 8'd22) begin bad++; $display("FAIL b2b_head: got %0d want 22", irq_vector); end
        step();
        irq_take = 1'b1;
        step();
        irq_take = 1'b0;
        total++;
        if (irq_vector !== 8'd23) begin bad++; $display("FAIL b2b_tail: got %0d want 23", irq_vector); end
        drain();
    endtask

    task automatic test_random();
        logic [7:0] exp_vec;
        for (int c = 0; c < 400; c++) begin
            notify = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            processor_id = ($urandom_range(0, 3) == 0) ? 8'd9 : MY_ID;
            lineno = 8'($urandom);
            irq_take = ($urandom_range(0, 2) == 0);
            irq_en = ($urandom_range(0, 4) != 0);
            step();
            exp_vec = (m_q.size() != 0) ? m_q[0] : 8'h00;
            total += 5;
            if (irqack !== m_ack) begin bad++; $display("FAIL rnd_ack: cycle %0d got %b want %b", c, irqack, m_ack); end
            if (rx_stall !== m_stall) begin bad++; $display("FAIL rnd_stall: cycle %0d got %b want %b", c, rx_stall, m_stall); end
            if (fifo_count !== 3'(m_q.size())) begin
                bad++; $display("FAIL rnd_count: cycle %0d got %0d want %0d", c, fifo_count, m_q.size());
            end
            if (irq_vector !== exp_vec) begin bad++; $display("FAIL rnd_vector: cycle %0d got %h want %h", c, irq_vector, exp_vec); end
            if (irq_pending !== ((m_q.size() != 0) && irq_en)) begin
                bad++; $display("FAIL rnd_pending: cycle %0d got %b want %b", c, irq_pending, (m_q.size() != 0) && irq_en);
            end
        end
        notify = 1'b1; irq_take = 1'b0; irq_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_other_cpu();
        test_full_stall();
        test_mask();
        test_reset_mid_ack();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
